// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: round-robin sharing of the single UART command engine
// among N_REQ requesters. One transaction is outstanding at a time; the
// result (write ack, read data or timeout error) is routed back to the
// requester that was granted.
module uart_cmd_arbiter #(
   parameter int N_REQ      = 4,
   parameter int CMD_WIDTH  = 16,
   parameter int READ_WIDTH = 8,
   parameter int TIMEOUT    = 20000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_vld,
   input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
   output logic [N_REQ-1:0]           req_rdy,
   output logic [N_REQ-1:0]           rsp_vld,
   output logic [READ_WIDTH-1:0]      rsp_data,
   output logic                       rsp_err,
   output logic [CMD_WIDTH-1:0]       uart_cmd,
   output logic                       uart_cmd_vld,
   input  logic                       uart_cmd_rdy,
   input  logic                       uart_read_rdy,
   input  logic [READ_WIDTH-1:0]      uart_read_data
);

   localparam int GW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] PTR_RESET  = GW'(N_REQ - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [GW-1:0]           ptr;
   logic [GW-1:0]           grant;
   logic [GW-1:0]           rr_winner;
   logic [GW-1:0]           lo_win;
   logic [GW-1:0]           hi_win;
   logic                    hi_found;
   logic [CMD_WIDTH-1:0]    win_cmd;
   logic [CMD_WIDTH-1:0]    cmd_q;
   logic                    is_write;
   logic [TW-1:0]           timer;
   logic [READ_WIDTH-1:0]   data_q;
   logic                    err_q;
   logic                    timeout_hit;
   logic                    read_done;
   logic                    write_done;

   // The timer has counted its last allowed cycle when it sits at TIMEOUT-1,
   // so the response lands exactly TIMEOUT cycles after entering ISSUE.
   assign timeout_hit = (timer == TIMER_LAST);
   assign read_done   = (state == WAIT_DONE) && !is_write && uart_read_rdy;
   assign write_done  = (state == WAIT_DONE) && is_write && uart_cmd_rdy;

   // Round-robin pick: lowest active index above ptr, else lowest active index overall.
   always_comb begin
      lo_win   = '0;
      hi_win   = '0;
      hi_found = 1'b0;
      win_cmd  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_vld[i]) begin
            lo_win = GW'(i);
            if (GW'(i) > ptr) begin
               hi_win   = GW'(i);
               hi_found = 1'b1;
            end
         end
      end
      rr_winner = hi_found ? hi_win : lo_win;
      for (int i = 0; i < N_REQ; i++) begin
         if (GW'(i) == rr_winner) begin
            win_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
         end
      end
   end

   // State register; reset drops any in-flight transaction without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode; outputs are zero outside their owning state.
   always_comb begin
      state_next   = state;
      req_rdy      = '0;
      rsp_vld      = '0;
      rsp_data     = '0;
      rsp_err      = 1'b0;
      uart_cmd     = '0;
      uart_cmd_vld = 1'b0;
      case (state)
         IDLE: begin
            if (|req_vld) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            uart_cmd     = cmd_q;
            uart_cmd_vld = 1'b1;
            if (uart_cmd_rdy) begin
               req_rdy[grant] = 1'b1;
               state_next     = WAIT_BUSY;
            end
            if (timeout_hit) begin
               state_next = RESP;
            end
         end
         WAIT_BUSY: begin
            if (timeout_hit) begin
               state_next = RESP;
            end else if (!uart_cmd_rdy) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (read_done || write_done || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_vld[grant] = 1'b1;
            rsp_data       = data_q;
            rsp_err        = err_q;
            state_next     = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant latch, timeout timer and result capture; completion beats a same-cycle timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= PTR_RESET;
         grant    <= '0;
         cmd_q    <= '0;
         is_write <= 1'b0;
         timer    <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_vld) begin
                  grant    <= rr_winner;
                  ptr      <= rr_winner;
                  cmd_q    <= win_cmd;
                  is_write <= win_cmd[CMD_WIDTH-1];
                  timer    <= '0;
                  data_q   <= '0;
                  err_q    <= 1'b0;
               end
            end
            ISSUE, WAIT_BUSY: begin
               timer <= timer + TW'(1);
               if (timeout_hit) begin
                  err_q <= 1'b1;
               end
            end
            WAIT_DONE: begin
               timer <= timer + TW'(1);
               if (read_done) begin
                  data_q <= uart_read_data;
               end else if (!write_done && timeout_hit) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// tb_uart_cmd_arbiter: table-driven transactions against a behavioural UART
// engine, with a scoreboard of expected grants and responses checked by a
// negedge monitor, plus hand-written fairness, ISSUE-timeout and reset runs.
module tb_uart_cmd_arbiter;

   localparam int N_REQ      = 4;
   localparam int CMD_WIDTH  = 16;
   localparam int READ_WIDTH = 8;
   localparam int TIMEOUT    = 300;
   localparam int NVEC       = 9;

   logic                       clk;
   logic                       rst_n;
   logic [N_REQ-1:0]           req_vld;
   logic [N_REQ*CMD_WIDTH-1:0] req_cmd;
   logic [N_REQ-1:0]           req_rdy;
   logic [N_REQ-1:0]           rsp_vld;
   logic [READ_WIDTH-1:0]      rsp_data;
   logic                       rsp_err;
   logic [CMD_WIDTH-1:0]       uart_cmd;
   logic                       uart_cmd_vld;
   logic                       uart_cmd_rdy;
   logic                       uart_read_rdy;
   logic [READ_WIDTH-1:0]      uart_read_data;

   typedef struct {
      int          req;
      logic [15:0] cmd;
      int          busy;
      logic [7:0]  rd;
      logic        hang;
      logic [7:0]  exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      int          req;
      logic [15:0] cmd;
      logic [7:0]  data;
      logic        err;
      int          lat;
      logic        rdy_exp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[NVEC];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   issue_cycle = 0;
   bit   issue_seen = 0;
   bit   rdy_seen = 0;

   uart_cmd_arbiter #(
      .N_REQ(N_REQ),
      .CMD_WIDTH(CMD_WIDTH),
      .READ_WIDTH(READ_WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_vld(req_vld),
      .req_cmd(req_cmd),
      .req_rdy(req_rdy),
      .rsp_vld(rsp_vld),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .uart_cmd(uart_cmd),
      .uart_cmd_vld(uart_cmd_vld),
      .uart_cmd_rdy(uart_cmd_rdy),
      .uart_read_rdy(uart_read_rdy),
      .uart_read_data(uart_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushExp(input int req, input logic [15:0] cmd, input logic [7:0] data,
                          input logic err, input int lat, input logic rdy_exp);
      exp_t e;
      e.req     = req;
      e.cmd     = cmd;
      e.data    = data;
      e.err     = err;
      e.lat     = lat;
      e.rdy_exp = rdy_exp;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input vec_t v);
      pushExp(v.req, v.cmd, v.exp_data, v.exp_err, v.exp_lat, 1'b1);
      req_cmd[v.req*CMD_WIDTH +: CMD_WIDTH] = v.cmd;
      req_vld[v.req] = 1'b1;
   endtask

   // Behavioural UART engine: accept, go busy, then finish (or hang forever).
   task automatic engineServe(input int busy, input bit is_read, input logic [7:0] rdata, input bit hang);
      int n;
      logic [N_REQ-1:0] got;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(uart_cmd_vld && uart_cmd_rdy) && n < 50);
      if (!(uart_cmd_vld && uart_cmd_rdy)) begin
         checkOutput("issue_wait", {31'b0, uart_cmd_vld}, 32'd1);
         return;
      end
      got = req_rdy;
      @(posedge clk); #1;
      req_vld      = req_vld & ~got;
      uart_cmd_rdy = 1'b0;
      if (hang) return;
      repeat (busy) begin
         @(posedge clk); #1;
      end
      if (is_read) begin
         uart_read_rdy  = 1'b1;
         uart_read_data = rdata;
         @(posedge clk); #1;
         uart_read_rdy  = 1'b0;
         uart_read_data = 8'hEE;
      end
      uart_cmd_rdy = 1'b1;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < TIMEOUT + 100) begin
         @(posedge clk);
         n++;
      end
      checkOutput("rsp_pending", sb.size(), 32'd0);
      sb.delete();
      issue_seen = 0;
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: issues, accepts and responses compared away from the clock edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (uart_cmd_vld && !issue_seen) begin
            issue_seen  = 1;
            issue_cycle = cyc;
            rdy_seen    = 0;
            if (sb.size() == 0) checkOutput("unexpected_issue", {31'b0, uart_cmd_vld}, 32'd0);
            else checkOutput("uart_cmd", {16'b0, uart_cmd}, {16'b0, sb[0].cmd});
         end
         if (req_rdy != '0) begin
            if (sb.size() == 0) checkOutput("unexpected_req_rdy", {28'b0, req_rdy}, 32'd0);
            else if (sb[0].rdy_exp) begin
               checkOutput("req_rdy", {28'b0, req_rdy}, 32'd1 << sb[0].req);
               rdy_seen = 1;
            end else checkOutput("req_rdy_on_timeout", {28'b0, req_rdy}, 32'd0);
         end
         if (rsp_vld != '0) begin
            if (sb.size() == 0) checkOutput("unexpected_rsp_vld", {28'b0, rsp_vld}, 32'd0);
            else begin
               mon_e = sb.pop_front();
               checkOutput("rsp_vld", {28'b0, rsp_vld}, 32'd1 << mon_e.req);
               checkOutput("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.data});
               checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
               checkOutput("rsp_latency", cyc - issue_cycle, mon_e.lat);
               checkOutput("rdy_rsp_overlap", {28'b0, req_rdy}, 32'd0);
               if (mon_e.rdy_exp) checkOutput("req_rdy_seen", {31'b0, rdy_seen}, 32'd1);
               issue_seen = 0;
            end
         end
      end
   end

   initial begin
      vecs[0] = '{2, 16'h0012, 4,           8'hA5, 1'b0, 8'hA5, 1'b0, 6};
      vecs[1] = '{0, 16'h8034, 100,         8'h00, 1'b0, 8'h00, 1'b0, 102};
      vecs[2] = '{1, 16'h0055, 1,           8'h3C, 1'b0, 8'h3C, 1'b0, 3};
      vecs[3] = '{3, 16'hFFFF, 7,           8'h00, 1'b0, 8'h00, 1'b0, 9};
      vecs[4] = '{3, 16'h7FFF, 2,           8'hFF, 1'b0, 8'hFF, 1'b0, 4};
      vecs[5] = '{1, 16'h0001, 0,           8'h00, 1'b1, 8'h00, 1'b1, TIMEOUT};
      vecs[6] = '{0, 16'h0002, TIMEOUT - 2, 8'h5A, 1'b0, 8'h5A, 1'b0, TIMEOUT};
      vecs[7] = '{2, 16'h8002, TIMEOUT - 2, 8'h00, 1'b0, 8'h00, 1'b0, TIMEOUT};
      vecs[8] = '{1, 16'h0003, TIMEOUT - 1, 8'hC3, 1'b0, 8'h00, 1'b1, TIMEOUT};

      rst_n          = 1'b0;
      req_vld        = '0;
      req_cmd        = '0;
      uart_cmd_rdy   = 1'b1;
      uart_read_rdy  = 1'b0;
      uart_read_data = 8'hEE;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rsp_side", {15'b0, req_rdy, rsp_vld, rsp_data, rsp_err}, 32'd0);
      checkOutput("reset_uart_side", {15'b0, uart_cmd, uart_cmd_vld}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fairness: all four requesters hold writes continuously
      for (int i = 0; i < N_REQ; i++) req_cmd[i*CMD_WIDTH +: CMD_WIDTH] = 16'h8100 + 16'(i);
      for (int k = 0; k < 6; k++) pushExp(k % N_REQ, 16'h8100 + 16'(k % N_REQ), 8'h00, 1'b0, 5, 1'b1);
      req_vld = 4'hF;
      for (int k = 0; k < 6; k++) begin
         engineServe(3, 1'b0, 8'h00, 1'b0);
         req_vld = (k < 5) ? 4'hF : 4'h0;
      end
      waitIdle();

      // Table-driven single transactions, including timeout and collision boundaries
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         engineServe(vecs[i].busy, !vecs[i].cmd[15], vecs[i].rd, vecs[i].hang);
         waitIdle();
         uart_cmd_rdy = 1'b1;
      end

      // Timeout while still in ISSUE: engine never ready, no req_rdy
      uart_cmd_rdy = 1'b0;
      pushExp(1, 16'h0033, 8'h00, 1'b1, TIMEOUT, 1'b0);
      req_cmd[1*CMD_WIDTH +: CMD_WIDTH] = 16'h0033;
      req_vld[1] = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      req_vld[1] = 1'b0;
      req_cmd[1*CMD_WIDTH +: CMD_WIDTH] = 16'hDEAD;
      waitIdle();
      checkOutput("cmd_vld_after_timeout", {31'b0, uart_cmd_vld}, 32'd0);
      uart_cmd_rdy = 1'b1;

      // Reset during WAIT_DONE, with a read strobe landing in the same cycle
      pushExp(2, 16'h0044, 8'h00, 1'b0, 0, 1'b1);
      req_cmd[2*CMD_WIDTH +: CMD_WIDTH] = 16'h0044;
      req_vld[2] = 1'b1;
      engineServe(0, 1'b1, 8'h00, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      uart_read_rdy  = 1'b1;
      uart_read_data = 8'h99;
      rst_n          = 1'b0;
      #1;
      checkOutput("midreset_rsp_side", {15'b0, req_rdy, rsp_vld, rsp_data, rsp_err}, 32'd0);
      checkOutput("midreset_uart_side", {15'b0, uart_cmd, uart_cmd_vld}, 32'd0);
      sb.delete();
      issue_seen = 0;
      rdy_seen   = 0;
      @(posedge clk); #1;
      uart_read_rdy  = 1'b0;
      uart_read_data = 8'hEE;
      @(posedge clk); #1;
      req_cmd[1*CMD_WIDTH +: CMD_WIDTH] = 16'h8011;
      req_cmd[3*CMD_WIDTH +: CMD_WIDTH] = 16'h8033;
      req_vld      = 4'b1010;
      uart_cmd_rdy = 1'b1;
      pushExp(1, 16'h8011, 8'h00, 1'b0, 4, 1'b1);
      pushExp(3, 16'h8033, 8'h00, 1'b0, 4, 1'b1);
      rst_n = 1'b1;
      engineServe(2, 1'b0, 8'h00, 1'b0);
      engineServe(2, 1'b0, 8'h00, 1'b0);
      waitIdle();
      repeat (10) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
